fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_buf.sv | 78 +++++++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_state_e : fetch FSM states (run / flush of stale responses)
//   PcInc         : sequential fetch increment
//   buf_entry_t   : fetch-buffer entry {pc, inst, filled}
//   align_pc()    : clears the two low address bits of a redirect target
package fetch_unit_pkg;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StFlush = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PcInc = 32'h4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        filled;
  } buf_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// In-order fetch buffer: entries are allocated when a request is accepted,
// filled in order by memory responses, and popped in order by decode.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   clr_i                 drop every entry (redirect)
//   alloc_i, alloc_pc_i   allocate a new tail entry for a request
//   fill_i, fill_inst_i   fill the oldest unfilled entry
//   pop_i                 remove the head entry
//   head_pc_o/inst_o/filled_o  head entry contents (filled_o is 0 when empty)
//   count_o               allocated entries
//   pend_o                allocated but not yet filled entries
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ENTRIES = 2,
  parameter int unsigned CntW    = $clog2(ENTRIES) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            alloc_i,
  input  logic [31:0]     alloc_pc_i,
  input  logic            fill_i,
  input  logic [31:0]     fill_inst_i,
  input  logic            pop_i,
  output logic [31:0]     head_pc_o,
  output logic [31:0]     head_inst_o,
  output logic            head_filled_o,
  output logic [CntW-1:0] count_o,
  output logic [CntW-1:0] pend_o
);

  localparam int unsigned PtrW = $clog2(ENTRIES);

  // ENTRIES is a power of two, so the pointers wrap naturally.
  logic [PtrW-1:0] rd_q, wr_q, fl_q;
  logic [CntW-1:0] cnt_q, pend_q;
  buf_entry_t      mem_q [ENTRIES];

  // Entry storage carries no reset: an entry is only visible once it has
  // been allocated, and allocation rewrites it completely.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !clr_i) begin
      if (alloc_i) begin
        mem_q[wr_q] <= '{pc: alloc_pc_i, inst: 32'h0, filled: 1'b0};
      end
      if (fill_i) begin
        mem_q[fl_q].inst   <= fill_inst_i;
        mem_q[fl_q].filled <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      rd_q   <= '0;
      wr_q   <= '0;
      fl_q   <= '0;
      cnt_q  <= '0;
      pend_q <= '0;
    end else begin
      if (alloc_i) wr_q <= wr_q + PtrW'(1);
      if (fill_i)  fl_q <= fl_q + PtrW'(1);
      if (pop_i)   rd_q <= rd_q + PtrW'(1);
      cnt_q  <= cnt_q + CntW'(alloc_i) - CntW'(pop_i);
      pend_q <= pend_q + CntW'(alloc_i) - CntW'(fill_i);
    end
  end

  always_comb begin
    head_pc_o     = mem_q[rd_q].pc;
    head_inst_o   = mem_q[rd_q].inst;
    head_filled_o = (cnt_q != '0) && mem_q[rd_q].filled;
    count_o       = cnt_q;
    pend_o        = pend_q;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, buffers returned
// instructions in order for decode, and handles redirects by flushing the
// buffer and discarding responses still in flight.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   redirect, redirect_pc         taken branch/jump and its target
//   imem_req_valid/ready/addr     instruction memory request channel
//   imem_rsp_valid/data           in-order instruction return (latency >= 1)
//   id_valid/ready, id_inst/pc    decode handoff
//   fetch_misalign                misaligned redirect trap (only when
//                                 FETCH_MISALIGN_TRAP_EN is defined)
// Parameters: RESET_PC first fetch address; ENTRIES buffer depth (2 or 4).
// Build option: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects
// instead of silently clearing the low target bits.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ENTRIES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int unsigned CntW = $clog2(ENTRIES) + 1;

  fetch_state_e    state_q;
  logic [31:0]     pc_q;
  logic [CntW-1:0] drop_q;

  logic [31:0]     head_pc, head_inst;
  logic            head_filled;
  logic [CntW-1:0] buf_cnt, buf_pend;
  logic            buf_full, pop, accept, fill;
  logic [CntW-1:0] inflight_base, redir_drop;
  logic            rsp_hit, trap, hold_trap;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;
  assign trap           = redirect && (redirect_pc[1:0] != 2'b00);
  assign hold_trap      = misalign_q;
  assign fetch_misalign = misalign_q;
`else
  assign trap      = 1'b0;
  assign hold_trap = 1'b0;
`endif

  assign buf_full = (buf_cnt == CntW'(ENTRIES));

  // Redirect hides the head immediately so a stale instruction never leaves.
  assign id_valid = head_filled && !redirect && !rst;
  assign id_inst  = id_valid ? head_inst : 32'h0;
  assign id_pc    = id_valid ? head_pc : 32'h0;
  assign pop      = id_valid && id_ready;

  // A pop frees the head slot this cycle, so a full buffer may still request.
  assign imem_req_valid = !rst && (state_q == StRun) && (!buf_full || pop);
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  // In flush, responses are discarded rather than written to the buffer.
  assign fill = imem_rsp_valid && (state_q == StRun) && (buf_pend != '0);

  // Outstanding requests at a redirect: unfilled entries (or the remaining
  // drop count while flushing) plus one accepted now, minus a response
  // arriving now. A same-cycle request cannot return in the same cycle.
  always_comb begin
    inflight_base = (state_q == StFlush) ? drop_q : buf_pend;
    rsp_hit       = imem_rsp_valid && (inflight_base != '0);
    redir_drop    = inflight_base - CntW'(rsp_hit)
                  + CntW'(accept && (state_q == StRun));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      drop_q  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else if (redirect) begin
      pc_q    <= align_pc(redirect_pc);
      drop_q  <= redir_drop;
      state_q <= ((redir_drop != '0) || trap) ? StFlush : StRun;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= trap;
`endif
    end else begin
      unique case (state_q)
        StRun: begin
          if (accept) pc_q <= pc_q + PcInc;
        end
        StFlush: begin
          if (imem_rsp_valid && (drop_q != '0)) drop_q <= drop_q - CntW'(1);
          // A pending misalign trap parks the unit here until the next redirect.
          if (!hold_trap &&
              ((drop_q == '0) || ((drop_q == CntW'(1)) && imem_rsp_valid))) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  fetch_buf #(
    .ENTRIES(ENTRIES),
    .CntW   (CntW)
  ) u_buf (
    .clk_i        (clk),
    .rst_i        (rst),
    .clr_i        (redirect),
    .alloc_i      (accept),
    .alloc_pc_i   (pc_q),
    .fill_i       (fill),
    .fill_inst_i  (imem_rsp_data),
    .pop_i        (pop),
    .head_pc_o    (head_pc),
    .head_inst_o  (head_inst),
    .head_filled_o(head_filled),
    .count_o      (buf_cnt),
    .pend_o       (buf_pend)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned ENTRIES  = 2;

  logic        clk = 1'b0;
  logic        rst, redirect, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        id_valid, id_ready;
  logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, id_inst, id_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
  logic        s_misalign;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] sb_q[$];    // expected id_pc order
  logic [31:0] mem_q[$];   // accepted, not yet returned by memory model
  logic [31:0] acc_log[$]; // accepted addresses
  bit          rsp_en;
  int          accepts;

  logic        s_req_valid, s_id_valid;
  logic [31:0] s_req_addr, s_id_pc, s_id_inst;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC(RESET_PC),
    .ENTRIES (ENTRIES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_inst       (id_inst),
    .id_pc         (id_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign(fetch_misalign)
`endif
  );

  // One clock period: memory model drives its response, outputs are sampled
  // mid-cycle, the scoreboard is updated, then the rising edge passes.
  task automatic cycle();
    logic [31:0] exp;
    @(negedge clk);
    if (rsp_en && mem_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~mem_q[0];
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_id_valid  = id_valid;
    s_id_pc     = id_pc;
    s_id_inst   = id_inst;
`ifdef FETCH_MISALIGN_TRAP_EN
    s_misalign  = fetch_misalign;
`endif
    if (id_valid && id_ready) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_pop: got id_pc=%h id_inst=%h, expected no instruction", id_pc, id_inst);
      end else begin
        exp = sb_q.pop_front();
        if (id_pc !== exp || id_inst !== ~exp) begin
          bad++;
          $display("FAIL sb_pop: got pc=%h inst=%h, expected pc=%h inst=%h",
                   id_pc, id_inst, exp, ~exp);
        end
      end
    end
    if (imem_rsp_valid) void'(mem_q.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      mem_q.push_back(imem_req_addr);
      sb_q.push_back(imem_req_addr);
      acc_log.push_back(imem_req_addr);
      accepts++;
    end
    if (redirect) sb_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; id_ready = 1'b0; rsp_en = 1'b0;
    cycle();
    cycle();
    mem_q.delete(); sb_q.delete(); acc_log.delete(); accepts = 0;
  endtask

  task automatic drain();
    int n = 0;
    imem_req_ready = 1'b0; id_ready = 1'b1; rsp_en = 1'b1; redirect = 1'b0;
    while ((sb_q.size() != 0 || mem_q.size() != 0) && n < 50) begin
      cycle();
      n++;
    end
    total++;
    if (sb_q.size() != 0 || mem_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending sb=%0d mem=%0d, expected 0 and 0", sb_q.size(), mem_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    cycle();
    total++;
    if (s_req_valid !== 1'b0 || s_id_valid !== 1'b0 || s_id_inst !== 32'h0 || s_id_pc !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got req_valid=%b id_valid=%b inst=%h pc=%h, expected 0 0 0 0",
               s_req_valid, s_id_valid, s_id_inst, s_id_pc);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    total++;
    if (s_misalign !== 1'b0) begin
      bad++;
      $display("FAIL reset_misalign: got %b, expected 0", s_misalign);
    end
`endif
    rst = 1'b0;
    cycle();
    total++;
    if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin
      bad++;
      $display("FAIL reset_first_req: got valid=%b addr=%h, expected 1 %h",
               s_req_valid, s_req_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    bit seen = 0;
    int gaps = 0;
    int pops = 0;
    do_reset();
    rst = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1; rsp_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (seen && !s_id_valid) gaps++;
      if (s_id_valid) begin seen = 1; pops++; end
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (acc_log[i] !== RESET_PC + 32'(4 * i)) begin
        bad++;
        $display("FAIL stream_addr[%0d]: got %h, expected %h", i, acc_log[i], RESET_PC + 32'(4 * i));
      end
    end
    total++;
    if (gaps != 0 || pops < 15) begin
      bad++;
      $display("FAIL stream_gaps: got gaps=%0d pops=%0d, expected 0 and >=15", gaps, pops);
    end
    drain();
  endtask

  task automatic test_stall();
    do_reset();
    rst = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b0; rsp_en = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    total++;
    if (accepts != ENTRIES || s_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_full: got accepts=%0d req_valid=%b, expected %0d 0",
               accepts, s_req_valid, ENTRIES);
    end
    id_ready = 1'b1;
    cycle();
    total++;
    if (s_id_valid !== 1'b1 || s_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_pop_req: got id_valid=%b req_valid=%b, expected 1 1", s_id_valid, s_req_valid);
    end
    drain();
  endtask

  task automatic test_redirect();
    int n = 0;
    do_reset();
    rst = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b0; rsp_en = 1'b0;
    cycle();
    cycle();
    imem_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    cycle();
    total++;
    if (s_id_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_hide: got id_valid=%b, expected 0", s_id_valid);
    end
    redirect = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1; rsp_en = 1'b1;
    cycle();
    total++;
    if (s_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_flush_req: got req_valid=%b, expected 0", s_req_valid);
    end
    while (!s_id_valid && n < 20) begin
      cycle();
      n++;
    end
    total++;
    if (s_id_valid !== 1'b1 || s_id_pc !== 32'h100) begin
      bad++;
      $display("FAIL redir_first_pc: got valid=%b pc=%h, expected 1 00000100", s_id_valid, s_id_pc);
    end
    drain();
  endtask

  task automatic test_redirect_coincident();
    // Steady stream: redirect meets a response and a ready decode; nothing
    // new is accepted, the one outstanding response returns now -> no flush.
    do_reset();
    rst = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1; rsp_en = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    redirect = 1'b1; redirect_pc = 32'h200;
    cycle();
    total++;
    if (s_id_valid !== 1'b0) begin
      bad++;
      $display("FAIL coinc_hide: got id_valid=%b, expected 0", s_id_valid);
    end
    redirect = 1'b0;
    cycle();
    total++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h200) begin
      bad++;
      $display("FAIL coinc_refetch: got valid=%b addr=%h, expected 1 00000200", s_req_valid, s_req_addr);
    end
    for (int i = 0; i < 8; i++) cycle();
    drain();
    // One in flight, its response plus a new accept in the redirect cycle:
    // exactly one response remains to drop.
    do_reset();
    rst = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b0; rsp_en = 1'b0;
    cycle();
    rsp_en = 1'b1; redirect = 1'b1; redirect_pc = 32'h240;
    cycle();
    redirect = 1'b0; id_ready = 1'b1;
    cycle();
    total++;
    if (s_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL coinc_drop1: got req_valid=%b, expected 0", s_req_valid);
    end
    cycle();
    total++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h240) begin
      bad++;
      $display("FAIL coinc_drop1_req: got valid=%b addr=%h, expected 1 00000240", s_req_valid, s_req_addr);
    end
    for (int i = 0; i < 6; i++) cycle();
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    rst = 1'b0; imem_req_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1; rsp_en = 1'b1;
    cycle();
    total++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_first: got valid=%b addr=%h, expected 1 fffffffc", s_req_valid, s_req_addr);
    end
    cycle();
    cycle();
    total++;
    if (acc_log.size() < 2 || acc_log[1] !== 32'h0) begin
      bad++;
      $display("FAIL wrap_next: got n=%0d addr=%h, expected 2+ 00000000",
               acc_log.size(), (acc_log.size() > 1) ? acc_log[1] : 32'hx);
    end
    drain();
  endtask

  task automatic test_misalign();
    do_reset();
    rst = 1'b0; imem_req_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h102;
    cycle();
    redirect = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1; rsp_en = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 5; i++) cycle();
    total++;
    if (s_misalign !== 1'b1 || accepts != 0) begin
      bad++;
      $display("FAIL misalign_hold: got misalign=%b accepts=%0d, expected 1 0", s_misalign, accepts);
    end
    redirect = 1'b1; redirect_pc = 32'h300;
    cycle();
    redirect = 1'b0;
    cycle();
    total++;
    if (s_misalign !== 1'b0 || s_req_valid !== 1'b1 || s_req_addr !== 32'h300) begin
      bad++;
      $display("FAIL misalign_clear: got misalign=%b valid=%b addr=%h, expected 0 1 00000300",
               s_misalign, s_req_valid, s_req_addr);
    end
`else
    cycle();
    total++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100) begin
      bad++;
      $display("FAIL misalign_clear_bits: got valid=%b addr=%h, expected 1 00000100",
               s_req_valid, s_req_addr);
    end
`endif
    drain();
  endtask

  task automatic test_back_to_back();
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 3) != 0);
      rsp_en         = ($urandom_range(0, 2) != 0);
      redirect       = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom() & 32'hFFFF_FFFC;
      cycle();
    end
    redirect = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    accepts = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_coincident();
    test_wrap();
    test_misalign();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
